// File: rtl/hiscore_ram_arbiter.sv
// Shares the work-RAM port between the main CPU and the hiscore engine.
// The hiscore side gets the port only after a pause handshake and a settle period.
module hiscore_ram_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 8,
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          hs_access,
    input  logic [AW-1:0] hs_addr,
    input  logic [DW-1:0] hs_wdata,
    input  logic          hs_we,
    output logic [DW-1:0] hs_rdata,
    output logic          hs_rvalid,
    output logic          hs_grant,
    output logic          hs_abort,
    output logic          pause_req,
    input  logic          cpu_paused,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    output logic [DW-1:0] cpu_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_SETTLE  = 3'd2,
        S_GRANT   = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [9:0] WAIT_LAST   = 10'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [9:0]    wait_q, wait_d;
    logic          pause_req_q;
    logic          hs_grant_q;
    logic          rd_pend_q;
    logic          hs_rvalid_q;
    logic [DW-1:0] hs_rdata_q;
    logic          granted;
    logic          hs_read;

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        wait_d   = '0;
        hs_abort = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hs_access) state_d = S_REQ;
            end
            S_REQ: begin
                if (!hs_access) begin
                    state_d = S_RELEASE;
                end else if (cpu_paused) begin
                    state_d = S_SETTLE;
                end else if (wait_q == WAIT_LAST) begin
                    hs_abort = 1'b1;
                    state_d  = S_RELEASE;
                end else begin
                    wait_d = wait_q + 10'd1;
                end
            end
            S_SETTLE: begin
                if (!hs_access) begin
                    state_d = S_RELEASE;
                end else if (!cpu_paused) begin
                    state_d = S_REQ;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = S_GRANT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_GRANT: begin
                if (!hs_access) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                // A user pause keeps cpu_paused high, so leave after one cycle regardless.
                if (!cpu_paused || cnt_q != 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Once hs_access drops, the final granted cycle may still read but never write.
    always_comb begin
        granted   = (state_q == S_GRANT);
        hs_read   = granted && !hs_we;
        ram_addr  = granted ? hs_addr  : cpu_addr;
        ram_wdata = granted ? hs_wdata : cpu_wdata;
        ram_we    = granted ? (hs_we && hs_access) : cpu_we;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wait_q      <= '0;
            pause_req_q <= 1'b0;
            hs_grant_q  <= 1'b0;
            rd_pend_q   <= 1'b0;
            hs_rvalid_q <= 1'b0;
            hs_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            pause_req_q <= (state_d == S_REQ) || (state_d == S_SETTLE) || (state_d == S_GRANT);
            hs_grant_q  <= (state_d == S_GRANT);
            rd_pend_q   <= hs_read;
            hs_rvalid_q <= rd_pend_q;
            if (rd_pend_q) hs_rdata_q <= ram_rdata;
        end
    end

    assign pause_req = pause_req_q;
    assign hs_grant  = hs_grant_q;
    assign hs_rvalid = hs_rvalid_q;
    assign hs_rdata  = hs_rdata_q;
    assign cpu_rdata = ram_rdata;

endmodule
